// File: rtl/serial_add_arb.sv
// serial_add_arb
//   Two-requester round-robin arbiter in front of a bit-serial adder.
//   A granted requester's operands are captured, then added one bit per
//   cycle (LSB first) over WIDTH cycles; the result is presented with a
//   one-cycle done pulse and held until the next result.
//
//   Optional feature: define SERIAL_ADD_ARB_OVF_EN to add the ovf output
//   (signed two's-complement overflow of the presented result).
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   req0 / req1    add request from requester 0 / 1
//   a0, b0         operands of requester 0 (WIDTH)
//   a1, b1         operands of requester 1 (WIDTH)
//   gnt0 / gnt1    one-cycle grant (combinational, IDLE only)
//   busy           serial add in progress
//   done           one-cycle result-valid pulse
//   done_id        requester whose result is presented
//   sum, cout      result and final carry (held until next done)
//   ovf            signed overflow (only with SERIAL_ADD_ARB_OVF_EN)
//
// state  | meaning
// -------+---------------------------------------------------
// S_IDLE | waiting for a request; grants issued here only
// S_RUN  | one result bit per cycle, WIDTH cycles
// S_DONE | result presented, done high for this one cycle
module serial_add_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_ARB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_id_q, done_id_d;
`ifdef SERIAL_ADD_ARB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Two cascaded half adders plus OR form the full adder for this bit.
    logic s1, c1, bit_s, carry_nx;
    assign s1       = a_sh_q[0] ^ b_sh_q[0];
    assign c1       = a_sh_q[0] & b_sh_q[0];
    assign bit_s    = s1 ^ carry_q;
    assign carry_nx = c1 | (s1 & carry_q);

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        done_id_d = done_id_q;
`ifdef SERIAL_ADD_ARB_OVF_EN
        ovf_d     = ovf_q;
`endif
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Gated by rst_n so no grant is shown while reset wins the edge.
                // On a tie the requester not served last wins (last_q==1 -> 0 wins).
                if (rst_n) begin
                    if (req0 && (!req1 || last_q)) begin
                        gnt0 = 1'b1;
                    end else if (req1) begin
                        gnt1 = 1'b1;
                    end
                end
                if (gnt0 || gnt1) begin
                    a_sh_d  = gnt1 ? a1 : a0;
                    b_sh_d  = gnt1 ? b1 : b0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    last_d  = gnt1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                acc_d   = {bit_s, acc_q[WIDTH-1:1]};
                carry_d = carry_nx;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Publish straight from the final bit so the result is
                    // valid in the same cycle done is high.
                    sum_d     = {bit_s, acc_q[WIDTH-1:1]};
                    cout_d    = carry_nx;
                    done_id_d = last_q;
`ifdef SERIAL_ADD_ARB_OVF_EN
                    ovf_d     = carry_q ^ carry_nx;
`endif
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            done_id_q <= 1'b0;
`ifdef SERIAL_ADD_ARB_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            done_id_q <= done_id_d;
`ifdef SERIAL_ADD_ARB_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign sum     = sum_q;
    assign cout    = cout_q;
    assign done_id = done_id_q;
`ifdef SERIAL_ADD_ARB_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_arb.sv
// Testbench for serial_add_arb (WIDTH=8): directed scenarios plus a
// randomized loop, checked against a transaction-level model that knows
// only the arbitration rule, the cycle timing and plain a+b arithmetic.
module tb_serial_add_arb;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         gnt0, gnt1, busy, done, done_id, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_ARB_OVF_EN
    logic         ovf;
`endif

    serial_add_arb #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum),
        .cout    (cout)
`ifdef SERIAL_ADD_ARB_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit last_id = 1'b1;          // model: requester served last
    logic [W-1:0] held_sum = '0; // model: result currently presented

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction starting in an IDLE cycle (C0).
    // keep : leave the granted req high afterwards
    // late1: raise req1 during the third RUN cycle
    task automatic add_txn(input logic r0, input logic r1,
                           input logic [W-1:0] x0, input logic [W-1:0] y0,
                           input logic [W-1:0] x1, input logic [W-1:0] y1,
                           input bit keep, input bit late1);
        bit           id;
        logic [W-1:0] ea, eb;
        logic [W:0]   full;
        bit           eovf;
        req0 = r0; req1 = r1;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        #1;
        id = (r0 && r1) ? ~last_id : r1;
        chk("gnt0_c0", gnt0, id == 1'b0);
        chk("gnt1_c0", gnt1, id == 1'b1);
        chk("busy_c0", busy, 1'b0);
        ea   = id ? x1 : x0;
        eb   = id ? y1 : y0;
        full = {1'b0, ea} + {1'b0, eb};
        eovf = (ea[W-1] == eb[W-1]) && (full[W-1] != ea[W-1]);
        tick();
        if (!keep) begin
            if (id) req1 = 1'b0; else req0 = 1'b0;
        end
        // operands of the granted requester no longer matter
        if (id) begin a1 = W'($urandom); b1 = W'($urandom); end
        else    begin a0 = W'($urandom); b0 = W'($urandom); end
        for (int k = 1; k <= W; k++) begin
            if (late1 && k == 3) req1 = 1'b1;
            #1;
            chk("busy_run", busy, 1'b1);
            chk("done_run", done, 1'b0);
            chk("gnt_run", {gnt1, gnt0}, 2'b00);
            tick();
        end
        chk("done_c9", done, 1'b1);
        chk("busy_c9", busy, 1'b0);
        chk("gnt_c9", {gnt1, gnt0}, 2'b00);
        chk("sum", sum, full[W-1:0]);
        chk("cout", cout, full[W]);
        chk("done_id", done_id, id);
`ifdef SERIAL_ADD_ARB_OVF_EN
        chk("ovf", ovf, eovf);
`endif
        last_id  = id;
        held_sum = full[W-1:0];
        tick();
        chk("done_c10", done, 1'b0);
        chk("sum_hold", sum, held_sum);
    endtask

    initial begin
        // reset
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_gnt", {gnt1, gnt0}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_done_id", done_id, 1'b0);
`ifdef SERIAL_ADD_ARB_OVF_EN
        chk("rst_ovf", ovf, 1'b0);
`endif
        rst_n = 1'b1;
        tick();
        chk("idle_nogrant", {gnt1, gnt0}, 2'b00);

        // basic adds
        add_txn(1, 0, 8'h0F, 8'h01, 8'h00, 8'h00, 0, 0);
        add_txn(0, 1, 8'h00, 8'h00, 8'hFF, 8'h01, 0, 0);
        add_txn(1, 0, 8'h7F, 8'h01, 8'h00, 8'h00, 0, 0);
        add_txn(0, 1, 8'h00, 8'h00, 8'h80, 8'h80, 0, 0);

        // req1 arrives during requester 0's add, served right after
        add_txn(1, 0, 8'h33, 8'h44, 8'hA5, 8'h5A, 0, 1);
        add_txn(0, 1, 8'h00, 8'h00, 8'hA5, 8'h5A, 0, 0);

        // reset into IDLE: tie must go to requester 0 first, then alternate
        req0 = 1'b0; req1 = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        last_id = 1'b1;
        held_sum = '0;
        for (int i = 0; i < 4; i++) begin
            add_txn(1, 1, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1, 0);
        end

        // reset in the middle of an add: discarded, no done
        req0 = 1'b1; req1 = 1'b0;
        a0 = 8'hC3; b0 = 8'h3C;
        #1;
        chk("mid_gnt0", gnt0, 1'b1);
        tick();
        req0 = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_busy_c4", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        last_id = 1'b1;
        held_sum = '0;
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", done, 1'b0);
        chk("mid_sum", sum, 0);
        chk("mid_cout", cout, 1'b0);
        chk("mid_done_id", done_id, 1'b0);
        begin
            int seen_done;
            seen_done = 0;
            for (int k = 0; k < W + 4; k++) begin
                if (done === 1'b1) seen_done++;
                tick();
            end
            chk("mid_no_done", seen_done, 0);
        end

        // randomized transactions
        for (int i = 0; i < 20; i++) begin
            logic [1:0] r;
            bit         late;
            r    = 2'($urandom_range(1, 3));
            late = (r == 2'b01) && ($urandom_range(0, 1) == 1);
            add_txn(r[0], r[1], W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0, late);
            if ($urandom_range(0, 2) == 0) begin
                req0 = 1'b0; req1 = 1'b0;
                #1;
                chk("rand_idle_gnt", {gnt1, gnt0}, 2'b00);
                tick();
                chk("rand_idle_busy", busy, 1'b0);
                chk("rand_idle_sum", sum, held_sum);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
